// File: rtl/inv_subbytes_iter.sv
// Iterative AES InvSubBytes engine: applies the inverse S-box to a 128-bit state,
// LANES bytes per cycle, with valid/ready handshakes on both sides.
module inv_subbytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int NSTEP = 16 / LANES;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
    $error("inv_subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 inverse S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    inv_sbox = INV_SBOX[11'd2047 - {b, 3'd0} -: 8];
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e            state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic [127:0]    work_r, work_nxt_s, work_sub_s;
  logic            in_ready_r, out_valid_r, busy_r;
  logic            in_ready_nxt_s, out_valid_nxt_s, busy_nxt_s;

  // Working register with the current lane group replaced by its inverse S-box values.
  always_comb begin
    work_sub_s = work_r;
    for (int j = 0; j < LANES; j++) begin
      work_sub_s[127 - 8*(int'(cnt_r)*LANES + j) -: 8] =
        inv_sbox(work_r[127 - 8*(int'(cnt_r)*LANES + j) -: 8]);
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    work_nxt_s  = work_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          work_nxt_s  = state_in;
          cnt_nxt_s   = '0;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        work_nxt_s = work_sub_s;
        if (cnt_r == LAST_STEP) begin
          // Park the counter at zero so it never exceeds NSTEP-1.
          cnt_nxt_s   = '0;
          state_nxt_s = DONE;
        end else begin
          cnt_nxt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
    in_ready_nxt_s  = (state_nxt_s == IDLE);
    out_valid_nxt_s = (state_nxt_s == DONE);
    busy_nxt_s      = (state_nxt_s == RUN) || (state_nxt_s == DONE);
  end

  // State, counter, working register and output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      work_r      <= 128'h0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      work_r      <= work_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign state_out = work_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_inv_subbytes_iter.sv
// Self-checking bench for inv_subbytes_iter: three instances (LANES 4, 1, 16) checked
// every cycle against a GF(2^8)-derived S-box model plus directed literal vectors.
module tb_inv_subbytes_iter;

  localparam int ND = 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid  [ND];
  logic         in_ready  [ND];
  logic [127:0] state_in  [ND];
  logic         out_valid [ND];
  logic         out_ready [ND];
  logic [127:0] state_out [ND];
  logic         busy      [ND];

  int tests = 0;
  int fails = 0;

  logic [7:0] sbox [256];
  logic [7:0] isb  [256];

  // Behavioural protocol model: 0 idle, 1 running, 2 done.
  int           m_ph  [ND];
  int           m_rem [ND];
  logic [127:0] m_exp [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    inv_subbytes_iter #(.LANES(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .state_in  (state_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .state_out (state_out[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nstep_of(input int d);
    case (d)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = isb[s[127-8*i -: 8]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        m_ph[d]  <= 0;
        m_rem[d] <= 0;
      end else if (m_ph[d] == 0) begin
        if (in_valid[d]) begin
          m_exp[d] <= inv_state(state_in[d]);
          m_rem[d] <= nstep_of(d);
          m_ph[d]  <= 1;
        end
      end else if (m_ph[d] == 1) begin
        if (m_rem[d] > 1) m_rem[d] <= m_rem[d] - 1;
        else m_ph[d] <= 2;
      end else if (out_ready[d]) begin
        m_ph[d] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("in_ready%0d", d), in_ready[d], m_ph[d] == 0);
      chk($sformatf("out_valid%0d", d), out_valid[d], m_ph[d] == 2);
      chk($sformatf("busy%0d", d), busy[d], m_ph[d] != 0);
      if (m_ph[d] == 2) chk($sformatf("state_out%0d", d), state_out[d], m_exp[d]);
    end
  end

  task automatic send(input int d, input logic [127:0] s);
    int n;
    n = 0;
    in_valid[d] = 1'b1;
    state_in[d] = s;
    while (in_ready[d] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("send_timeout", 1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic recv(input int d, input logic [127:0] exp, input int lat_exp, input string nm);
    int n;
    n = 0;
    out_ready[d] = 1'b1;
    while (out_valid[d] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, lat_exp);
    chk({nm, "_data"}, state_out[d], exp);
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    chk({nm, "_valid_drop"}, out_valid[d], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s, e;
    logic [127:0] rnd [3];
    logic [7:0]   inv, v;
    int           k, c, last;
    logic         ir;

    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      state_in[d]  = 128'h0;
    end

    // Forward S-box from the field inverse and affine map; inverse table by inversion.
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      v = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
          {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[a] = v;
      isb[v]  = 8'(a);
    end
    chk("model_sbox00", sbox[0], 8'h63);
    chk("model_inv00", isb[8'h00], 8'h52);
    chk("model_inv01", isb[8'h01], 8'h09);
    chk("model_inv63", isb[8'h63], 8'h00);
    chk("model_inv7c", isb[8'h7c], 8'h01);
    chk("model_inv16", isb[8'h16], 8'hff);
    chk("model_invff", isb[8'hff], 8'h7d);
    chk("model_inv52", isb[8'h52], 8'h48);

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("rst_in_ready", in_ready[d], 1'b1);
      chk("rst_out_valid", out_valid[d], 1'b0);
      chk("rst_busy", busy[d], 1'b0);
      chk("rst_state_out", state_out[d], 128'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(0, 128'h637c777bf26b6fc53001672bfed7ab76);
    recv(0, 128'h000102030405060708090a0b0c0d0e0f, 4, "known_vec");
    send(0, {16{8'h63}});
    recv(0, 128'h0, 4, "all63");
    send(0, {16{8'h16}});
    recv(0, {16{8'hff}}, 4, "all16");

    // Backpressure: hold the result, offer a new state that must wait.
    send(0, 128'h637c777bf26b6fc53001672bfed7ab76);
    k = 0;
    while (out_valid[0] !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_latency", k, 4);
    in_valid[0] = 1'b1;
    state_in[0] = 128'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", state_out[0], 128'h000102030405060708090a0b0c0d0e0f);
      chk("bp_hold_valid", out_valid[0], 1'b1);
      chk("bp_hold_ready", in_ready[0], 1'b0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk("bp_release_ready", in_ready[0], 1'b1);
    chk("bp_release_valid", out_valid[0], 1'b0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("bp_pending_busy", busy[0], 1'b1);
    recv(0, {16{8'h52}}, 4, "bp_pending");

    // Reset in the middle of RUN discards the partial result.
    send(0, {16{8'h63}});
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready[0], 1'b1);
    chk("midrst_out_valid", out_valid[0], 1'b0);
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_state_out", state_out[0], 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 128'h637c777bf26b6fc53001672bfed7ab76);
    recv(0, 128'h000102030405060708090a0b0c0d0e0f, 4, "post_rst");

    // Round trip over every byte value for each lane count.
    for (int d = 0; d < ND; d++) begin
      for (int blk = 0; blk < 16; blk++) begin
        for (int i = 0; i < 16; i++) begin
          s[127-8*i -: 8] = sbox[blk*16 + i];
          e[127-8*i -: 8] = 8'(blk*16 + i);
        end
        send(d, s);
        recv(d, e, nstep_of(d), $sformatf("roundtrip%0d", d));
      end
    end

    // Back-to-back with both handshakes held high.
    for (int i = 0; i < 3; i++) rnd[i] = {$urandom, $urandom, $urandom, $urandom};
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    state_in[0]  = rnd[0];
    k = 0;
    c = 0;
    last = 0;
    while (k < 3 && c < 100) begin
      ir = in_ready[0];
      @(posedge clk); #1;
      c++;
      if (ir) begin
        if (k > 0) chk("b2b_interval", c - last, 6);
        last = c;
        k++;
        if (k < 3) state_in[0] = rnd[k];
      end
    end
    in_valid[0] = 1'b0;
    chk("b2b_accepts", k, 3);
    repeat (8) @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    chk("b2b_drain_valid", out_valid[0], 1'b0);
    chk("b2b_drain_ready", in_ready[0], 1'b1);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
